clk_div_bank: RTL and testbench

//   Multi-channel programmable clock-enable/divider generator, successor to the single fixed-ratio divider.
//   NUM_CH independent channels each produce a square wave clkout[ch] and a one-cycle tick[ch] at the same rate.
//   Per-channel divisor is runtime-loadable through a shadow register, applied glitch-free at the period boundary.

---
 rtl/clk_div_pkg.sv | 22 ++
 rtl/clk_div_chan.sv | 88 ++++++++
 rtl/clk_div_bank.sv | 62 ++++++
 tb/tb_clk_div_bank.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_div_pkg.sv
// clk_div_pkg
//   Shared definitions for the multi-channel clock divider bank:
//   default counter width, reset divisor, counter type and the helper
//   that sizes the channel-select index.
package clk_div_pkg;

  // Default counter / divisor width.
  localparam int CNT_W_DEF = 32;

  // Divisor loaded into every channel on reset.
  localparam int unsigned DEFAULT_DIV_DEF = 25000;

  // Counter / divisor value at the default width.
  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // Width of the channel-select index. A single-channel bank still
  // gets a one-bit index, so that out-of-range selects stay expressible.
  function automatic int ch_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// clk_div_chan
//   One divider channel. It holds the running counter, the active
//   divisor, the shadow divisor with its pending flag, and the
//   registered clkout/tick outputs.
// Ports
//   clkin    in   1      system clock (posedge)
//   rst      in   1      synchronous active-high reset
//   en       in   1      run enable; low holds the channel idle at phase 0
//   restart  in   1      bank-wide phase restart, same effect as en low
//   wr       in   1      decoded divisor write strobe for this channel
//   div_val  in   CNT_W  divisor carried by wr
//   clkout   out  1      divided clock, toggles every div_cur+1 cycles
//   tick     out  1      one-cycle pulse on each clkout toggle
//   pending  out  1      shadow written but not yet in use
module clk_div_chan import clk_div_pkg::*; #(
  parameter int              CNT_W       = CNT_W_DEF,
  parameter logic [CNT_W-1:0] DEFAULT_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic             en,
  input  logic             restart,
  input  logic             wr,
  input  logic [CNT_W-1:0] div_val,
  output logic             clkout,
  output logic             tick,
  output logic             pending
);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] div_cur_reg;
  logic [CNT_W-1:0] shadow_reg;
  logic             pending_reg;
  logic             clkout_reg;
  logic             tick_reg;

  logic             terminal;
  logic [CNT_W-1:0] div_next;

  assign terminal = (cnt_reg == div_cur_reg);

  // A write that lands on an apply point bypasses the shadow so the
  // newest value takes effect at this boundary rather than one later.
  assign div_next = wr ? div_val : shadow_reg;

  always_ff @(posedge clkin) begin
    if (rst) begin
      cnt_reg     <= '0;
      div_cur_reg <= DEFAULT_DIV;
      shadow_reg  <= DEFAULT_DIV;
      pending_reg <= 1'b0;
      clkout_reg  <= 1'b0;
      tick_reg    <= 1'b0;
    end else begin
      if (wr) begin
        shadow_reg <= div_val;
      end

      if (restart || !en) begin
        // Idle at phase 0; an idle channel has no period to protect,
        // so the shadow goes live at once.
        cnt_reg     <= '0;
        clkout_reg  <= 1'b0;
        tick_reg    <= 1'b0;
        div_cur_reg <= div_next;
        pending_reg <= 1'b0;
      end else if (terminal) begin
        // Half-period boundary: the only glitch-free point to swap divisors.
        cnt_reg     <= '0;
        clkout_reg  <= ~clkout_reg;
        tick_reg    <= 1'b1;
        div_cur_reg <= div_next;
        pending_reg <= 1'b0;
      end else begin
        cnt_reg  <= cnt_reg + CNT_W'(1);
        tick_reg <= 1'b0;
        if (wr) begin
          pending_reg <= 1'b1;
        end
      end
    end
  end

  assign clkout  = clkout_reg;
  assign tick    = tick_reg;
  assign pending = pending_reg;

endmodule

// File: rtl/clk_div_bank.sv
// clk_div_bank
//   Bank of NUM_CH independent programmable clock dividers. Each channel
//   produces a square wave and a matching one-cycle tick. Divisors are
//   written through a per-channel shadow and applied at a half-period
//   boundary.
// Ports
//   clkin         in   1       system clock (posedge)
//   rst           in   1       synchronous active-high reset
//   en            in   NUM_CH  per-channel run enable
//   sync_restart  in   1       restart every channel at phase 0
//   div_wr        in   1       divisor write strobe
//   div_ch        in   CH_W    target channel; out-of-range values are ignored
//   div_val       in   CNT_W   new divisor
//   clkout        out  NUM_CH  divided clocks
//   tick          out  NUM_CH  toggle pulses
//   pending       out  NUM_CH  shadow written but not yet applied
module clk_div_bank import clk_div_pkg::*; #(
  parameter int          NUM_CH      = 4,
  parameter int          CNT_W       = CNT_W_DEF,
  parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEF
) (
  input  logic                          clkin,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             en,
  input  logic                          sync_restart,
  input  logic                          div_wr,
  input  logic [ch_idx_w(NUM_CH)-1:0]   div_ch,
  input  logic [CNT_W-1:0]              div_val,
  output logic [NUM_CH-1:0]             clkout,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH-1:0]             pending
);

  // When NUM_CH is not a power of two, the index can name channels
  // that do not exist; such writes must not reach any channel.
  logic              ch_in_range;
  logic [NUM_CH-1:0] wr_sel;

  assign ch_in_range = (int'(div_ch) < NUM_CH);

  generate
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
      assign wr_sel[gi] = div_wr && ch_in_range && (int'(div_ch) == gi);

      clk_div_chan #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (CNT_W'(DEFAULT_DIV))
      ) u_chan (
        .clkin   (clkin),
        .rst     (rst),
        .en      (en[gi]),
        .restart (sync_restart),
        .wr      (wr_sel[gi]),
        .div_val (div_val),
        .clkout  (clkout[gi]),
        .tick    (tick[gi]),
        .pending (pending[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clk_div_bank.sv
// tb_clk_div_bank
//   Self-checking bench for clk_div_bank. Instance A: 4 channels at the
//   default width and reset divisor. Instance B: 3 channels, 8-bit
//   counters, reset divisor 7, so that an out-of-range channel index
//   exists. An event-time reference model checks every cycle; directed
//   sequences and a table check the corner cases.
module tb_clk_div_bank;
  import clk_div_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance A
  logic       a_rst = 1'b0, a_restart = 1'b0, a_wr = 1'b0;
  logic [3:0] a_en = 4'h0;
  logic [1:0] a_ch = 2'd0;
  cnt_t       a_val = '0;
  logic [3:0] a_clkout, a_tick, a_pending;

  // Instance B
  logic       b_rst = 1'b0, b_restart = 1'b0, b_wr = 1'b0;
  logic [2:0] b_en = 3'h0;
  logic [1:0] b_ch = 2'd0;
  logic [7:0] b_val = '0;
  logic [2:0] b_clkout, b_tick, b_pending;

  clk_div_bank #(.NUM_CH(4), .CNT_W(32), .DEFAULT_DIV(25000)) dut_a (
    .clkin(clk), .rst(a_rst), .en(a_en), .sync_restart(a_restart),
    .div_wr(a_wr), .div_ch(a_ch), .div_val(a_val),
    .clkout(a_clkout), .tick(a_tick), .pending(a_pending)
  );

  clk_div_bank #(.NUM_CH(3), .CNT_W(8), .DEFAULT_DIV(7)) dut_b (
    .clkin(clk), .rst(b_rst), .en(b_en), .sync_restart(b_restart),
    .div_wr(b_wr), .div_ch(b_ch), .div_val(b_val),
    .clkout(b_clkout), .tick(b_tick), .pending(b_pending)
  );

  int     n_assert = 0;
  int     n_fail   = 0;
  longint cyc      = 0;

  // Reference model: each channel is described by the absolute cycle of
  // its next toggle, its output level, and the divisor it is running.
  longint unsigned m_d[2][4], m_sh[2][4], m_next[2][4];
  bit              m_lvl[2][4], m_tick[2][4], m_pend[2][4];

  task automatic check(input string name, input longint unsigned got, input longint unsigned want);
    n_assert++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, got, want);
    end
  endtask

  task automatic model_step(input int inst, input bit r, input bit rs, input bit [3:0] e,
                            input bit w, input int c, input longint unsigned v,
                            input int nch, input longint unsigned defd);
    for (int ch = 0; ch < nch; ch++) begin
      bit hit;
      hit = w && (c == ch);
      if (r) begin
        m_d[inst][ch] = defd; m_sh[inst][ch] = defd; m_pend[inst][ch] = 0;
        m_lvl[inst][ch] = 0; m_tick[inst][ch] = 0;
        m_next[inst][ch] = cyc + defd + 1;
      end else if (rs || !e[ch]) begin
        if (hit) m_sh[inst][ch] = v;
        m_d[inst][ch] = m_sh[inst][ch]; m_pend[inst][ch] = 0;
        m_lvl[inst][ch] = 0; m_tick[inst][ch] = 0;
        m_next[inst][ch] = cyc + m_d[inst][ch] + 1;
      end else if (cyc == m_next[inst][ch]) begin
        if (hit) m_sh[inst][ch] = v;
        m_lvl[inst][ch] = !m_lvl[inst][ch]; m_tick[inst][ch] = 1;
        m_d[inst][ch] = m_sh[inst][ch]; m_pend[inst][ch] = 0;
        m_next[inst][ch] = cyc + m_d[inst][ch] + 1;
      end else begin
        m_tick[inst][ch] = 0;
        if (hit) begin
          m_sh[inst][ch] = v; m_pend[inst][ch] = 1;
        end
      end
    end
  endtask

  function automatic longint unsigned model_vec(input int inst, input int nch);
    longint unsigned cv, tv, pv;
    cv = 0; tv = 0; pv = 0;
    for (int ch = 0; ch < nch; ch++) begin
      cv |= longint'(m_lvl[inst][ch])  << ch;
      tv |= longint'(m_tick[inst][ch]) << ch;
      pv |= longint'(m_pend[inst][ch]) << ch;
    end
    return (cv << (2 * nch)) | (tv << nch) | pv;
  endfunction

  // One clock: inputs are sampled at posedge, outputs compared at negedge,
  // one-shot strobes are cleared afterwards.
  task automatic step();
    @(posedge clk);
    cyc++;
    model_step(0, a_rst, a_restart, a_en, a_wr, int'(a_ch), longint'(a_val), 4, 25000);
    model_step(1, b_rst, b_restart, {1'b0, b_en}, b_wr, int'(b_ch), longint'(b_val), 3, 7);
    @(negedge clk);
    check("model_a", {a_clkout, a_tick, a_pending}, model_vec(0, 4));
    check("model_b", {b_clkout, b_tick, b_pending}, model_vec(1, 3));
    a_rst = 0; a_restart = 0; a_wr = 0;
    b_rst = 0; b_restart = 0; b_wr = 0;
  endtask

  typedef struct {
    bit       restart;
    bit [1:0] exp_clk;
    bit [1:0] exp_tick;
  } vec_t;

  vec_t tbl[13];

  initial begin
    #6_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint  c0;
    bit      found;
    bit      prev;
    int      pend_cnt;
    longint  tmask;
    logic [3:0] acc;

    // ch0 D=3, ch1 D=5 after a sync_restart at offset 0:
    // ch0 toggles at +4/+8/+12, ch1 at +6/+12.
    tbl[0]  = '{1'b1, 2'b00, 2'b00};
    tbl[1]  = '{1'b0, 2'b00, 2'b00};
    tbl[2]  = '{1'b0, 2'b00, 2'b00};
    tbl[3]  = '{1'b0, 2'b00, 2'b00};
    tbl[4]  = '{1'b0, 2'b01, 2'b01};
    tbl[5]  = '{1'b0, 2'b01, 2'b00};
    tbl[6]  = '{1'b0, 2'b11, 2'b10};
    tbl[7]  = '{1'b0, 2'b11, 2'b00};
    tbl[8]  = '{1'b0, 2'b10, 2'b01};
    tbl[9]  = '{1'b0, 2'b10, 2'b00};
    tbl[10] = '{1'b0, 2'b10, 2'b00};
    tbl[11] = '{1'b0, 2'b10, 2'b00};
    tbl[12] = '{1'b0, 2'b01, 2'b11};

    // Reset, then free-run at the default divisor.
    a_rst = 1; b_rst = 1; a_en = 4'hF; b_en = 3'h7;
    step();
    check("reset_a", {a_clkout, a_tick, a_pending}, 0);
    check("reset_b", {b_clkout, b_tick, b_pending}, 0);
    c0 = cyc; found = 0;
    for (int k = 0; k < 26000 && !found; k++) begin
      step();
      if (a_clkout[0]) found = 1;
    end
    check("first_rise", cyc - c0, 25001);
    check("first_tick", a_tick[0], 1);
    check("pending_idle", a_pending, 0);
    c0 = cyc; found = 0;
    for (int k = 0; k < 26000 && !found; k++) begin
      step();
      if (a_tick[0]) found = 1;
    end
    check("tick_interval", cyc - c0, 25001);

    // ch1: D=0 gives clkin/2 with tick held high; then D=2 by bypass write.
    a_wr = 1; a_ch = 1; a_val = 0; step();
    check("d0_pending", a_pending[1], 1);
    a_en[1] = 0; step();
    check("d0_idle", {a_clkout[1], a_pending[1]}, 0);
    a_en[1] = 1; prev = a_clkout[1];
    for (int k = 0; k < 6; k++) begin
      step();
      check("d0_toggle", a_clkout[1], !prev);
      check("d0_tick", a_tick[1], 1);
      prev = a_clkout[1];
    end
    a_wr = 1; a_ch = 1; a_val = 2; step();
    check("bypass_pending", a_pending[1], 0);
    for (int k = 1; k <= 9; k++) begin
      step();
      check("d2_tick", a_tick[1], (k % 3 == 0));
    end

    // ch2: running D=9, write D=4 on the edge that makes cnt 3.
    a_wr = 1; a_ch = 2; a_val = 9; step();
    a_en[2] = 0; step();
    a_en[2] = 1; step(); step();
    a_wr = 1; a_ch = 2; a_val = 4; step();
    pend_cnt = a_pending[2] ? 1 : 0;
    tmask = 0;
    for (int k = 4; k <= 22; k++) begin
      step();
      if (a_pending[2]) pend_cnt++;
      if (a_tick[2]) tmask |= longint'(1) << k;
    end
    check("late_write_pending_len", pend_cnt, 7);
    check("late_write_ticks", tmask, (longint'(1) << 10) | (longint'(1) << 15) | (longint'(1) << 20));

    // Phase alignment through sync_restart.
    a_wr = 1; a_ch = 0; a_val = 3; step();
    a_wr = 1; a_ch = 1; a_val = 5; step();
    for (int k = 0; k < 13; k++) begin
      a_restart = tbl[k].restart;
      step();
      check("restart_clk", a_clkout[1:0], tbl[k].exp_clk);
      check("restart_tick", a_tick[1:0], tbl[k].exp_tick);
    end

    // ch3: en dropped with a pending write, then re-enabled.
    a_wr = 1; a_ch = 3; a_val = 6; step();
    check("en_drop_pending_before", a_pending[3], 1);
    a_en[3] = 0; step();
    check("en_drop_idle", {a_clkout[3], a_pending[3]}, 0);
    a_en[3] = 1;
    for (int k = 1; k <= 7; k++) begin
      step();
      check("reenable_tick", a_tick[3], (k == 7));
    end

    // Reset mid-run: outputs clear and divisors return to the default.
    a_rst = 1; step();
    check("midrun_reset", {a_clkout, a_tick, a_pending}, 0);
    acc = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      acc |= a_clkout | a_tick;
    end
    check("default_restored", acc, 0);

    // Instance B: a write to channel index 3 of a 3-channel bank is ignored.
    b_wr = 1; b_ch = 3; b_val = 8'd1; step();
    check("oob_write_pending", b_pending, 0);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (b_tick[0]) found = 1;
    end
    c0 = cyc; found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (b_tick[0]) found = 1;
    end
    check("oob_period_kept", cyc - c0, 8);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      a_rst     = ($urandom_range(0, 499) == 0);
      a_restart = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 4; i++) a_en[i] = ($urandom_range(0, 9) != 0);
      a_wr  = ($urandom_range(0, 3) == 0);
      a_ch  = 2'($urandom_range(0, 3));
      a_val = cnt_t'($urandom_range(0, 7));
      b_rst     = ($urandom_range(0, 499) == 0);
      b_restart = ($urandom_range(0, 99) == 0);
      for (int i = 0; i < 3; i++) b_en[i] = ($urandom_range(0, 9) != 0);
      b_wr  = ($urandom_range(0, 3) == 0);
      b_ch  = 2'($urandom_range(0, 3));
      b_val = 8'($urandom_range(0, 7));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
